ac97_rx_deframer: RTL



---
 rtl/ac97_pkg.sv | 26 ++
 rtl/ac97_rx_deframer_if.sv | 29 ++
 rtl/ac97_edge_sync.sv | 40 ++++
 rtl/ac97_rx_deframer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - AC97 frame layout constants shared by the link transmitter and receiver
package ac97_pkg;

    localparam int FRAME_BITS = 256;

    // bit_index of the last bit of each slot that the receiver decodes
    localparam logic [7:0] LAST_BIT  = 8'(FRAME_BITS - 1);
    localparam logic [7:0] SLOT0_END = 8'd15;
    localparam logic [7:0] SLOT1_END = 8'd35;
    localparam logic [7:0] SLOT2_END = 8'd55;
    localparam logic [7:0] SLOT3_END = 8'd75;
    localparam logic [7:0] SLOT4_END = 8'd95;

    // slot 0 tag bit positions
    localparam int TAG_READY = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    typedef enum logic {
        IDLE,
        RECV
    } rx_state_t;

endpackage

// File: rtl/ac97_rx_deframer_if.sv
// rtl/ac97_rx_deframer_if.sv - decoded receive results from the AC97 deframer
// master: the deframer (drives everything); slave: downstream recorder logic.
// codec_ready, status_addr/status_data/status_valid, audio_left_in/audio_right_in/
// audio_in_valid, frame_error, bit_index.
interface ac97_rx_deframer_if #(
    parameter int SAMPLE_BITS = 18
);
    logic                   codec_ready;
    logic [7:0]             status_addr;
    logic [15:0]            status_data;
    logic                   status_valid;
    logic [SAMPLE_BITS-1:0] audio_left_in;
    logic [SAMPLE_BITS-1:0] audio_right_in;
    logic                   audio_in_valid;
    logic                   frame_error;
    logic [7:0]             bit_index;

    modport master (
        output codec_ready, status_addr, status_data, status_valid,
        output audio_left_in, audio_right_in, audio_in_valid,
        output frame_error, bit_index
    );

    modport slave (
        input codec_ready, status_addr, status_data, status_valid,
        input audio_left_in, audio_right_in, audio_in_valid,
        input frame_error, bit_index
    );
endinterface

// File: rtl/ac97_edge_sync.sv
// rtl/ac97_edge_sync.sv - synchronizes the AC97 link inputs and flags bit clock falling edges
// Ports: clock/reset (system), bit_clock/synch/sdata (async link inputs),
// sample_strobe (one clock per bit clock falling edge), synch_out/sdata_out (aligned bits).
module ac97_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic bit_clock,
    input  logic synch,
    input  logic sdata,
    output logic sample_strobe,
    output logic synch_out,
    output logic sdata_out
);
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] synch_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   bclk_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            bclk_sync  <= '0;
            synch_sync <= '0;
            sdata_sync <= '0;
            bclk_prev  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bit_clock};
            synch_sync <= {synch_sync[SYNC_STAGES-2:0], synch};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
            bclk_prev  <= bclk_sync[SYNC_STAGES-1];
        end
    end

    // All three inputs go through equal depth, so the data seen at the strobe is
    // the value the codec held across the falling edge.
    assign sample_strobe = bclk_prev & ~bclk_sync[SYNC_STAGES-1];
    assign synch_out     = synch_sync[SYNC_STAGES-1];
    assign sdata_out     = sdata_sync[SYNC_STAGES-1];
endmodule

// File: rtl/ac97_rx_deframer.sv
// rtl/ac97_rx_deframer.sv - deframes AC97 codec input into tags, status readback and PCM capture
// Ports: clock, reset (sync, active-high), ac97_bit_clock, ac97_synch, ac97_sdata_in
// (link inputs), rx (ac97_rx_deframer_if.master: decoded results and pulses).
module ac97_rx_deframer
    import ac97_pkg::*;
#(
    parameter int SAMPLE_BITS = 18,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ac97_bit_clock,
    input  logic                  ac97_synch,
    input  logic                  ac97_sdata_in,
    ac97_rx_deframer_if.master    rx
);
    logic sample_strobe;
    logic synch_s;
    logic sdata_s;

    ac97_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clock         (clock),
        .reset         (reset),
        .bit_clock     (ac97_bit_clock),
        .synch         (ac97_synch),
        .sdata         (ac97_sdata_in),
        .sample_strobe (sample_strobe),
        .synch_out     (synch_s),
        .sdata_out     (sdata_s)
    );

    rx_state_t              state;
    logic [7:0]             bit_idx;
    logic [18:0]            shreg;
    logic                   synch_prev;
    logic                   status_ok;     // tag says slots 1 and 2 carry valid data
    logic                   audio_ok;      // tag says slots 3 and 4 carry valid data
    logic [7:0]             addr_hold;
    logic [SAMPLE_BITS-1:0] left_hold;

    logic        sync_rise;
    logic [19:0] shift_next;

    always_comb begin
        sync_rise  = synch_s & ~synch_prev;
        // the full 20-bit slot including the bit captured at this sample
        shift_next = {shreg, sdata_s};
    end

    assign rx.bit_index = bit_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            bit_idx           <= '0;
            shreg             <= '0;
            // prev=1 forces a genuine 0->1 on synch before the first frame is armed
            synch_prev        <= 1'b1;
            status_ok         <= 1'b0;
            audio_ok          <= 1'b0;
            addr_hold         <= '0;
            left_hold         <= '0;
            rx.codec_ready    <= 1'b0;
            rx.status_addr    <= '0;
            rx.status_data    <= '0;
            rx.status_valid   <= 1'b0;
            rx.audio_left_in  <= '0;
            rx.audio_right_in <= '0;
            rx.audio_in_valid <= 1'b0;
            rx.frame_error    <= 1'b0;
        end else begin
            rx.status_valid   <= 1'b0;
            rx.audio_in_valid <= 1'b0;
            rx.frame_error    <= 1'b0;
            if (sample_strobe) begin
                synch_prev <= synch_s;
                case (state)
                    IDLE: begin
                        if (sync_rise) begin
                            state   <= RECV;
                            bit_idx <= '0;
                        end
                    end
                    RECV: begin
                        shreg <= shift_next[18:0];
                        if (sync_rise) begin
                            // synch rises during bit 255; anywhere else the frame is cut short
                            if (bit_idx != LAST_BIT) begin
                                rx.frame_error <= 1'b1;
                            end
                            bit_idx <= '0;
                        end else if (bit_idx == LAST_BIT) begin
                            rx.frame_error <= 1'b1;
                            state          <= IDLE;
                            bit_idx        <= '0;
                        end else begin
                            bit_idx <= bit_idx + 8'd1;
                            case (bit_idx)
                                SLOT0_END: begin
                                    rx.codec_ready <= shift_next[TAG_READY];
                                    status_ok <= shift_next[TAG_READY] & shift_next[TAG_SLOT1]
                                               & shift_next[TAG_SLOT2];
                                    audio_ok  <= shift_next[TAG_READY] & shift_next[TAG_SLOT3]
                                               & shift_next[TAG_SLOT4];
                                end
                                SLOT1_END: addr_hold <= shift_next[19:12];
                                SLOT2_END: begin
                                    if (status_ok) begin
                                        rx.status_addr  <= addr_hold;
                                        rx.status_data  <= shift_next[19:4];
                                        rx.status_valid <= 1'b1;
                                    end
                                end
                                SLOT3_END: left_hold <= shift_next[19 -: SAMPLE_BITS];
                                SLOT4_END: begin
                                    if (audio_ok) begin
                                        rx.audio_left_in  <= left_hold;
                                        rx.audio_right_in <= shift_next[19 -: SAMPLE_BITS];
                                        rx.audio_in_valid <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
